// File: rtl/pkg_tpu.sv
// Shared TPU scalar-unit types: hazard table depth, lane count, issue numbers
// and the commit-table row layout used by the vector commit controller.
package pkg_tpu;

    localparam int NUM_ENTRY_HAZARD   = 8;
    localparam int WIDTH_ENTRY_HAZARD = $clog2(NUM_ENTRY_HAZARD);
    localparam int NUM_LANE           = 16;

    typedef logic [WIDTH_ENTRY_HAZARD-1:0] issue_no_t;
    typedef logic [NUM_LANE-1:0]           lane_mask_t;

    // One row of the in-order commit table.
    typedef struct packed {
        logic       v;
        issue_no_t  issue_no;
        logic       commit;
        lane_mask_t en_lane;
        lane_mask_t en_commit;
    } commit_tab_v;

    // A row is complete once every participating lane has committed.
    function automatic logic row_complete(input logic v, input lane_mask_t en_lane,
                                          input lane_mask_t en_commit);
        return v & (&(en_commit | ~en_lane));
    endfunction

endpackage

// File: rtl/vcommit_entry.sv
// One commit-table row: written at grant, accumulates legal lane commits,
// cleared on retire. The complete flag is combinational from the stored row.
module vcommit_entry
    import pkg_tpu::*;
#(
    parameter int NUM_LANES = NUM_LANE,
    parameter int VEC_W     = WIDTH_ENTRY_HAZARD
) (
    input  logic                 gclk,
    input  logic                 grst_n,
    input  logic                 alloc,
    input  logic [VEC_W-1:0]     alloc_no,
    input  logic [NUM_LANES-1:0] alloc_mask,
    input  logic [NUM_LANES-1:0] commit_set,
    input  logic                 clr,
    output logic                 v,
    output logic [VEC_W-1:0]     issue_no,
    output logic [NUM_LANES-1:0] en_lane,
    output logic                 complete
);

    logic [NUM_LANES-1:0] en_commit;

    // Row state: allocation wins, then retire clear, then commit accumulation.
    // Allocation and clear never coincide on one slot since full blocks grant.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            v         <= 1'b0;
            issue_no  <= '0;
            en_lane   <= '0;
            en_commit <= '0;
        end else if (alloc) begin
            v         <= 1'b1;
            issue_no  <= alloc_no;
            en_lane   <= alloc_mask;
            en_commit <= '0;
        end else if (clr) begin
            v         <= 1'b0;
            en_commit <= '0;
        end else begin
            en_commit <= en_commit | commit_set;
        end
    end

    // Lanes not participating count as already committed, so an empty mask
    // completes as soon as the row is written.
    always_comb begin
        complete = v & (&(en_commit | ~en_lane));
    end

endmodule

// File: rtl/vcommit_ctrl.sv
// In-order commit controller for vector commands.
// Allocates issue numbers at the tail, collects per-lane commit pulses into
// the addressed rows and retires the head row once all its lanes committed.
// Build option: define VCOMMIT_ERR_CHECK_EN to detect illegal commits (sticky
// O_Err) and to flag issue requests made while the table is full.
module vcommit_ctrl #(
    parameter int NUM_ENTRY   = pkg_tpu::NUM_ENTRY_HAZARD,
    parameter int NUM_LANE    = pkg_tpu::NUM_LANE,
    parameter int WIDTH_ENTRY = $clog2(NUM_ENTRY)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            I_Req_Issue,
    input  logic [NUM_LANE-1:0]             I_En_Lane,
    output logic                            O_Grant,
    output logic [WIDTH_ENTRY-1:0]          O_Issue_No,
    input  logic [NUM_LANE-1:0]             I_Commit,
    input  logic [NUM_LANE*WIDTH_ENTRY-1:0] I_Commit_No,
    output logic                            O_Retire,
    output logic [WIDTH_ENTRY-1:0]          O_Retire_No,
    output logic                            O_Full,
    output logic                            O_Empty,
    output logic [WIDTH_ENTRY:0]            O_Num_Active,
    output logic                            O_Err
);

    // Head/tail carry one extra wrap bit to tell full from empty.
    logic [WIDTH_ENTRY:0]   head, tail;
    logic [WIDTH_ENTRY-1:0] head_idx, tail_idx;
    logic                   retire_now;

    logic [NUM_ENTRY-1:0]                  row_v;
    logic [NUM_ENTRY-1:0]                  row_cmp;
    logic [NUM_ENTRY-1:0][WIDTH_ENTRY-1:0] row_no;
    logic [NUM_ENTRY-1:0][NUM_LANE-1:0]    row_en;
    logic [NUM_ENTRY-1:0][NUM_LANE-1:0]    commit_hit;
    logic [NUM_ENTRY-1:0][NUM_LANE-1:0]    commit_set;
    logic [NUM_ENTRY-1:0]                  row_alloc;
    logic [NUM_ENTRY-1:0]                  row_clr;

    assign head_idx = head[WIDTH_ENTRY-1:0];
    assign tail_idx = tail[WIDTH_ENTRY-1:0];

    // Occupancy flags and grant, all from pre-edge pointers (no retire bypass).
    always_comb begin
        O_Full       = (head ^ tail) == {1'b1, {WIDTH_ENTRY{1'b0}}};
        O_Empty      = head == tail;
        O_Num_Active = tail - head;
        O_Grant      = I_Req_Issue & ~O_Full;
        O_Issue_No   = tail_idx;
        retire_now   = row_cmp[head_idx];
    end

    // Commit decode: each lane addresses one row; only rows that are valid and
    // enabled for that lane accept it, everything else leaves the table alone.
    always_comb begin
        commit_hit = '0;
        commit_set = '0;
        for (int r = 0; r < NUM_ENTRY; r++) begin
            for (int k = 0; k < NUM_LANE; k++) begin
                commit_hit[r][k] = I_Commit[k] &&
                    (I_Commit_No[k*WIDTH_ENTRY +: WIDTH_ENTRY] == WIDTH_ENTRY'(r));
            end
            commit_set[r] = commit_hit[r] & row_en[r] & {NUM_LANE{row_v[r]}};
        end
    end

    // Per-row write strobes: grant writes the tail slot, retire clears the head.
    always_comb begin
        row_alloc = '0;
        row_clr   = '0;
        row_alloc[tail_idx] = O_Grant;
        row_clr[head_idx]   = retire_now;
    end

    for (genvar r = 0; r < NUM_ENTRY; r++) begin : g_row
        vcommit_entry #(
            .NUM_LANES (NUM_LANE),
            .VEC_W     (WIDTH_ENTRY)
        ) u_entry (
            .gclk       (clock),
            .grst_n     (reset),
            .alloc      (row_alloc[r]),
            .alloc_no   (tail_idx),
            .alloc_mask (I_En_Lane),
            .commit_set (commit_set[r]),
            .clr        (row_clr[r]),
            .v          (row_v[r]),
            .issue_no   (row_no[r]),
            .en_lane    (row_en[r]),
            .complete   (row_cmp[r])
        );
    end

    // Pointer advance and the registered retire pulse / number.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            O_Retire    <= 1'b0;
            O_Retire_No <= '0;
        end else begin
            if (O_Grant)    tail <= tail + 1'b1;
            if (retire_now) head <= head + 1'b1;
            O_Retire <= retire_now;
            if (retire_now) O_Retire_No <= row_no[head_idx];
        end
    end

`ifdef VCOMMIT_ERR_CHECK_EN
    logic commit_illegal;

    // A lane pulse that no row accepted is an illegal commit.
    always_comb begin
        commit_illegal = |(commit_hit & ~commit_set);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) O_Err <= 1'b0;
        else if (commit_illegal) O_Err <= 1'b1;
    end

    a_no_req_when_full: assert property (@(posedge clock) disable iff (!reset)
        !(I_Req_Issue && O_Full))
        else $error("vcommit_ctrl: issue request while table full");
`else
    assign O_Err = 1'b0;
`endif

endmodule

// File: tb/tb_vcommit_ctrl.sv
// Bench for vcommit_ctrl: directed scenarios followed by random traffic, all
// checked against a queue-based model of the in-order commit table.
module tb_vcommit_ctrl;

    localparam int NE = 8;
    localparam int NL = 16;
    localparam int WE = 3;
`ifdef VCOMMIT_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             req;
    logic [NL-1:0]    en;
    logic             grant;
    logic [WE-1:0]    issue_no;
    logic [NL-1:0]    commit;
    logic [NL*WE-1:0] commit_no;
    logic             retire;
    logic [WE-1:0]    retire_no;
    logic             full, empty;
    logic [WE:0]      num_active;
    logic             err;

    int checks = 0;
    int errors = 0;

    // Model: ordered list of live issue numbers plus per-slot masks.
    int          q[$];
    logic [15:0] mmask [NE];
    logic [15:0] mdone [NE];
    int          next_no;
    logic        exp_ret;
    int          exp_ret_no;
    logic        exp_err;

    vcommit_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .I_Req_Issue  (req),
        .I_En_Lane    (en),
        .O_Grant      (grant),
        .O_Issue_No   (issue_no),
        .I_Commit     (commit),
        .I_Commit_No  (commit_no),
        .O_Retire     (retire),
        .O_Retire_No  (retire_no),
        .O_Full       (full),
        .O_Empty      (empty),
        .O_Num_Active (num_active),
        .O_Err        (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit live(input int s);
        foreach (q[i]) if (q[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_in();
        req = 1'b0; en = '0; commit = '0; commit_no = '0;
    endtask

    task automatic set_commit(input int lane, input int no);
        commit[lane] = 1'b1;
        commit_no[lane*WE +: WE] = no[WE-1:0];
    endtask

    task automatic model_clear();
        q.delete();
        next_no = 0; exp_ret = 1'b0; exp_ret_no = 0; exp_err = 1'b0;
        for (int i = 0; i < NE; i++) begin mmask[i] = '0; mdone[i] = '0; end
    endtask

    // Check outputs for the current cycle, then advance the model across the edge.
    task automatic step(input string tag);
        int  cnt, h, s;
        bit  g, ret, ill;
        #1;
        cnt = q.size();
        g   = req && (cnt < NE);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        if (g) chk({tag, ".issue_no"}, 32'(issue_no), 32'(next_no));
        chk({tag, ".full"}, 32'(full), 32'(cnt == NE));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, ".num_active"}, 32'(num_active), 32'(cnt));
        chk({tag, ".retire"}, 32'(retire), 32'(exp_ret));
        chk({tag, ".retire_no"}, 32'(retire_no), 32'(exp_ret_no));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        ret = 1'b0; h = 0; ill = 1'b0;
        if (cnt > 0) begin
            h   = q[0];
            ret = ((mdone[h] | ~mmask[h]) == 16'hFFFF);
        end
        for (int k = 0; k < NL; k++) begin
            if (commit[k]) begin
                s = int'(commit_no[k*WE +: WE]);
                if (live(s) && mmask[s][k]) mdone[s][k] = 1'b1;
                else ill = 1'b1;
            end
        end
        if (ret) void'(q.pop_front());
        exp_ret = ret;
        if (ret) exp_ret_no = h;
        if (g) begin
            q.push_back(next_no);
            mmask[next_no] = en;
            mdone[next_no] = '0;
            next_no = (next_no + 1) % NE;
        end
        exp_err = exp_err | (ERR_EN & ill);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Asynchronous reset: registered outputs must clear immediately.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_clear();
        chk({tag, ".rst_empty"}, 32'(empty), 32'd1);
        chk({tag, ".rst_full"}, 32'(full), 32'd0);
        chk({tag, ".rst_active"}, 32'(num_active), 32'd0);
        chk({tag, ".rst_retire"}, 32'(retire), 32'd0);
        chk({tag, ".rst_retire_no"}, 32'(retire_no), 32'd0);
        chk({tag, ".rst_err"}, 32'(err), 32'd0);
        clear_in();
        #1;
        chk({tag, ".rst_grant"}, 32'(grant), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int s, t5no;
        reset = 1'b1;
        clear_in();
        model_clear();
        #2;

        // 1: single command on lanes 0..3, all commit together
        do_reset("t1");
        req = 1'b1; en = 16'h000F; step("t1.issue");
        clear_in(); for (int k = 0; k < 4; k++) set_commit(k, 0); step("t1.commit");
        clear_in(); step("t1.wait");
        step("t1.retire");
        step("t1.idle");

        // 2: fill to full, blocked 9th request, retire head, wrap to slot 0
        do_reset("t2");
        for (int i = 0; i < NE; i++) begin req = 1'b1; en = 16'h0001; step("t2.fill"); end
        req = 1'b1; step("t2.full");
        set_commit(0, 0); step("t2.c0");
        clear_in(); req = 1'b1; en = 16'h0001; step("t2.wait");
        step("t2.wrap");
        clear_in();
        for (int i = 1; i < NE; i++) begin clear_in(); set_commit(0, i); step("t2.drain"); end
        clear_in(); set_commit(0, 0); step("t2.drain0");
        clear_in();
        for (int i = 0; i < 10; i++) step("t2.flush");

        // 3: out-of-order completion retires in order
        do_reset("t3");
        for (int i = 0; i < 3; i++) begin req = 1'b1; en = 16'h0003; step("t3.issue"); end
        clear_in(); set_commit(0, 2); set_commit(1, 2); step("t3.c2");
        clear_in(); set_commit(0, 1); set_commit(1, 1); step("t3.c1");
        clear_in(); step("t3.hold");
        step("t3.hold2");
        set_commit(0, 0); set_commit(1, 0); step("t3.c0");
        clear_in();
        for (int i = 0; i < 5; i++) step("t3.retire");

        // 4: empty lane mask retires without any commit
        req = 1'b1; en = 16'h0000; step("t4.issue");
        clear_in(); step("t4.wait");
        step("t4.retire");

        // 5: illegal commits (disabled lane, invalid entry) leave table intact
        t5no = next_no;
        req = 1'b1; en = 16'h0001; step("t5.issue");
        clear_in(); set_commit(5, t5no); step("t5.bad_lane");
        clear_in(); set_commit(3, 6); step("t5.bad_entry");
        clear_in(); step("t5.hold");
        step("t5.hold2");
        set_commit(0, t5no); step("t5.good");
        clear_in();
        for (int i = 0; i < 3; i++) step("t5.retire");

        // 6: reset with live entries and a pending commit
        for (int i = 0; i < 3; i++) begin req = 1'b1; en = 16'h0001; step("t6.issue"); end
        s = q[0];
        clear_in(); set_commit(0, s); step("t6.c0");
        clear_in(); set_commit(0, q[1]);
        do_reset("t6");
        for (int i = 0; i < 3; i++) step("t6.quiet");
        req = 1'b1; en = 16'h0001; step("t6.reissue");
        clear_in(); step("t6.idle");

        // Random traffic with one mid-run reset
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) do_reset("rnd");
            clear_in();
            req = ($urandom_range(2) != 0);
            case ($urandom_range(3))
                0: en = 16'h0000;
                1: en = 16'(32'd1 << $urandom_range(15));
                2: en = 16'($urandom) & 16'h00FF;
                default: en = 16'($urandom);
            endcase
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(99) < 35) begin
                    if (q.size() > 0 && $urandom_range(99) < 93) begin
                        s = q[$urandom_range(q.size() - 1)];
                        if (mmask[s][k]) set_commit(k, s);
                    end else begin
                        set_commit(k, int'($urandom_range(NE - 1)));
                    end
                end
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vcommit_ctrl.md
Name: vcommit_ctrl

Overview:
In-order commit controller for vector commands, placed in the scalar unit.
- Allocates an issue_no_t for each vector command at issue and records its enabled-lane mask in a commit_tab_v table.
- Collects per-lane commit pulses from the vector lanes.
- Retires entries strictly in issue order, returning the issue number so the hazard check table can clear that slot.

Parameters:
NUM_ENTRY, NUM_ENTRY_HAZARD (8), table depth; must be a power of two.
NUM_LANE, pkg_tpu::NUM_LANE (16), number of vector lanes.
WIDTH_ENTRY, $clog2(NUM_ENTRY), issue-number width.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
I_Req_Issue  in  1  issue stage requests a slot for one vector command.
I_En_Lane  in  NUM_LANE  lanes participating in the requested command.
O_Grant  out  1  slot granted this cycle; combinational.
O_Issue_No  out  WIDTH_ENTRY  issue number assigned, equal to the tail pointer; valid when O_Grant=1.
I_Commit  in  NUM_LANE  per-lane commit pulse.
I_Commit_No  in  NUM_LANE*WIDTH_ENTRY  per-lane issue number; lane k uses bits [k*WIDTH_ENTRY +: WIDTH_ENTRY].
O_Retire  out  1  registered one-cycle pulse: head entry retired.
O_Retire_No  out  WIDTH_ENTRY  issue number of the retired entry.
O_Full  out  1  no free slot.
O_Empty  out  1  no active entry.
O_Num_Active  out  WIDTH_ENTRY+1  count of valid entries.
O_Err  out  1  sticky illegal-commit flag; see Optional Feature.

Behaviour:
- Table: NUM_ENTRY rows of commit_tab_v {v, issue_no, commit, en_lane, en_commit}.
- Pointers: head and tail, each WIDTH_ENTRY+1 bits wide, with the MSB used as wrap bit.
- O_Full = (head^tail) == {1, 0...}. O_Empty = head == tail. O_Num_Active = tail - head, modulo 2^(WIDTH_ENTRY+1).
- Reset (async, active-low), all cleared to 0: table, pointers, O_Retire, O_Retire_No, O_Err. Resulting outputs: O_Empty=1, O_Full=0, O_Grant=0. Reset mid-operation discards all in-flight entries; no retire pulses are emitted for them.
- Allocate: O_Grant = I_Req_Issue & ~O_Full. On a granted edge, row[tail] <= {v=1, issue_no=tail, commit=0, en_lane=I_En_Lane, en_commit=0}, and tail increments.
- Full is evaluated on pre-edge state. A retire in the same cycle does not enable a grant (no bypass).
- Commit: on each edge, for every lane k with I_Commit[k], row[I_Commit_No[k]].en_commit[k] <= 1.
  - All lanes are processed in parallel. Multiple lanes may target the same or different rows in one cycle.
  - A commit is illegal when the target row has v=0 or en_lane[k]=0. Illegal commits do not modify the table.
- Complete: row.commit = v & ((en_commit | ~en_lane) == all-ones), computed combinationally from the registered row.
- An empty I_En_Lane mask makes the row complete as soon as it is written.
- Retire: when row[head].commit=1, at the edge the controller:
  - clears row[head].v,
  - increments head,
  - sets O_Retire=1 and O_Retire_No=head[WIDTH_ENTRY-1:0].
  Otherwise O_Retire=0 and O_Retire_No holds its value. At most one retire per cycle.
- Latency:
  - Last lane commit sampled at edge E → row complete after E → retire at edge E+1 → O_Retire high in the cycle after E+1.
  - Empty-mask command granted at edge E → O_Retire high in the cycle after E+1.
- Out-of-order completion: younger complete rows wait until all older rows retire. Once the head completes, they then retire one per cycle.
- Simultaneous events:
  - Grant, commits and retire may all occur on one edge.
  - Retire of the head and grant into the same physical slot cannot coincide, because full blocks the grant.
  - A commit arriving on the same edge as that row's retire is legal but redundant. The row is cleared regardless.
- Pointer wrap: head and tail wrap modulo NUM_ENTRY. The wrap bit disambiguates full from empty.

Optional Feature:
VCOMMIT_ERR_CHECK_EN
- Defined: O_Err is set on the edge after any illegal commit and stays set until reset.
- Defined: a simulation-only assertion also fires on I_Req_Issue while O_Full=1.
- Undefined: illegality is neither detected nor flagged, O_Err is tied to 0, and the illegal-commit logic is absent. Illegal commits still do not modify the table.

Decomposition:
- pkg_tpu gains parameter NUM_LANE (default 16). It reuses commit_tab_v and issue_no_t, and adds typedef lane_mask_t = logic [NUM_LANE-1:0].
- One sub-module, vcommit_entry: a single table row with its set and clear logic and complete output. It is generated NUM_ENTRY times; the top level holds the pointers, the commit decode and the retire register.

Test Plan:
1. Reset, then request with En_Lane=16'h000F → O_Grant=1, O_Issue_No=0. Commit lanes 0..3 in one cycle with No=0 → O_Retire=1, O_Retire_No=0 two cycles after the commit; O_Empty=1.
2. Grant 8 requests → O_Full=1, O_Num_Active=8; a 9th request gets O_Grant=0. Retire entry 0, then request → O_Issue_No=0 (wrap); tail wrap bit toggles.
3. Issue nos 0, 1, 2 with En_Lane=16'h0003. Complete entry 2, then 1: no retire. Complete entry 0 → retires 0, 1, 2 on three consecutive cycles.
4. En_Lane=16'h0000 → granted and retired with no commit activity. O_Retire appears in the cycle after the edge following the grant.
5. With VCOMMIT_ERR_CHECK_EN: commit lane 5 to an entry whose En_Lane=16'h0001 → O_Err=1, entry unaffected. Commit to an invalid entry 6 → table unchanged.
6. Assert reset with 3 active entries and one pending commit → all outputs return to reset values. The next grant returns O_Issue_No=0 and no stale retire occurs.
